// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage in-order pipeline, with a one-deep fetch tracker.
// Optional stall-cycle counter port perf_stall_cnt is enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int PERF_CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ireq_fire,
  input  logic       iresp_valid,
  input  logic       load_use,
  input  logic       md_busy,
  input  logic       dresp_pending,
  input  logic       redirect,
  input  logic       trap,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       drop_iresp,
  output logic [1:0] ctrl_state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    IDROP = 2'd2
  } state_e;

  state_e state, state_nxt;

  logic stall_mem, stall_ex, stall_id;
  logic trap_eff, redirect_eff, fetch_ok;

  assign stall_mem    = dresp_pending;
  assign stall_ex     = dresp_pending | md_busy;
  assign stall_id     = stall_ex | load_use;
  assign trap_eff     = trap & ~dresp_pending;
  assign redirect_eff = redirect & ~stall_ex & ~trap_eff;
  assign fetch_ok     = iresp_valid & ((state == IWAIT) | ((state == RUN) & ireq_fire));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ireq_fire && !iresp_valid)
          state_nxt = (redirect_eff || trap_eff) ? IDROP : IWAIT;
      end
      IWAIT: begin
        if (iresp_valid)                      state_nxt = RUN;
        else if (redirect_eff || trap_eff)    state_nxt = IDROP;
      end
      IDROP: begin
        if (iresp_valid) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushM     = 1'b0;
    flushW     = 1'b0;
    drop_iresp = 1'b0;
    if (!reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      drop_iresp = (state == IDROP) & iresp_valid;
      if (trap_eff) begin
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
        flushW = 1'b1;
      end else if (redirect_eff) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else begin
        stallM = stall_mem;
        stallE = stall_ex;
        stallD = stall_id;
        stallF = stall_id | ~fetch_ok;
        flushW = stall_mem;
        flushM = md_busy & ~stall_mem;
        flushE = load_use & ~stall_ex;
        // A stalled IF/ID holds its instruction; only an unstalled one takes a bubble.
        flushD = ~fetch_ok & ~stall_id;
      end
    end
  end

  assign ctrl_state = state;

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset)      perf_stall_cnt <= '0;
    else if (stallF) perf_stall_cnt <= perf_stall_cnt + PERF_CNT_W'(1);
  end
`endif

endmodule
